// File: rtl/qspi_flash_reader.sv
// qspi_flash_reader: quad-SPI flash read engine.
// Sends READ_CMD (2 nibbles), a 24-bit address (6 nibbles) and DUMMY_CYCLES
// idle sclk periods, then assembles nibbles from data_in into bytes.
// sclk runs at clk/2: a low phase (cmd_addr_out changes) followed by a high phase
// (the flash samples on the rising sclk edge). Read data is captured on the clk edge
// that ends each high phase.
// Optional feature: define QSPI_SEQUENTIAL_STREAM_EN to keep streaming sequential
// bytes with select held low. Otherwise every byte ends with DESELECT and IDLE.
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   start, addr_in    begin (or abort and restart) a read at addr_in
//   stall_read        consumer back-pressure; freezes sclk in the data phase
//   data_in           nibble returned by the flash
//   sclk, select      flash serial clock, active-low chip select
//   cmd_addr_out      command/address nibble driven to the flash
//   data_out          last assembled byte; data_ready pulses one clk when it updates
//   busy              high whenever the engine is not idle
module qspi_flash_reader #(
  parameter int unsigned DUMMY_CYCLES = 4,
  parameter logic [7:0]  READ_CMD     = 8'hEB
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [23:0] addr_in,
  input  logic        stall_read,
  input  logic [3:0]  data_in,
  output logic        sclk,
  output logic        select,
  output logic [3:0]  cmd_addr_out,
  output logic [7:0]  data_out,
  output logic        data_ready,
  output logic        busy
);

  localparam int unsigned ADDR_W    = 24;
  localparam int unsigned NIB_W     = 4;
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned CNT_W     = 8;
  localparam int unsigned ADDR_NIBS = 6;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CMD      = 3'd1,
    ADDR     = 3'd2,
    DUMMY    = 3'd3,
    DATA     = 3'd4,
    DESELECT = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [NIB_W-1:0]    nib_q, nib_d;
  logic                restart_q, restart_d;
  logic                sclk_q, sclk_d;
  logic                select_q, select_d;
  logic [NIB_W-1:0]    cmd_addr_q, cmd_addr_d;
  logic [BYTE_W-1:0]   data_q, data_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;

  // Address nibble idx (0 = most significant) for the ADDR phase.
  function automatic logic [NIB_W-1:0] addr_nibble(input logic [ADDR_W-1:0] a,
                                                   input logic [CNT_W-1:0]  idx);
    case (idx)
      CNT_W'(0): addr_nibble = a[23:20];
      CNT_W'(1): addr_nibble = a[19:16];
      CNT_W'(2): addr_nibble = a[15:12];
      CNT_W'(3): addr_nibble = a[11:8];
      CNT_W'(4): addr_nibble = a[7:4];
      default:   addr_nibble = a[3:0];
    endcase
  endfunction

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      nib_q      <= '0;
      restart_q  <= 1'b0;
      sclk_q     <= 1'b0;
      select_q   <= 1'b1;
      cmd_addr_q <= '0;
      data_q     <= '0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      nib_q      <= nib_d;
      restart_q  <= restart_d;
      sclk_q     <= sclk_d;
      select_q   <= select_d;
      cmd_addr_q <= cmd_addr_d;
      data_q     <= data_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    nib_d      = nib_q;
    restart_d  = restart_q;
    sclk_d     = sclk_q;
    select_d   = select_q;
    cmd_addr_d = cmd_addr_q;
    data_d     = data_q;
    ready_d    = 1'b0;

    if (start && (state_q != IDLE)) begin
      // Abort: drop the in-flight read and reopen the device after DESELECT.
      state_d    = DESELECT;
      cnt_d      = '0;
      addr_d     = addr_in;
      restart_d  = 1'b1;
      sclk_d     = 1'b0;
      select_d   = 1'b1;
      cmd_addr_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          sclk_d     = 1'b0;
          select_d   = 1'b1;
          cmd_addr_d = '0;
          if (start) begin
            addr_d     = addr_in;
            state_d    = CMD;
            cnt_d      = '0;
            select_d   = 1'b0;
            cmd_addr_d = READ_CMD[7:4];
          end
        end

        CMD: begin
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            if (cnt_q == CNT_W'(0)) begin
              cnt_d      = CNT_W'(1);
              cmd_addr_d = READ_CMD[3:0];
            end else begin
              state_d    = ADDR;
              cnt_d      = '0;
              cmd_addr_d = addr_nibble(addr_q, CNT_W'(0));
            end
          end
        end

        ADDR: begin
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            if (cnt_q == CNT_W'(ADDR_NIBS - 1)) begin
              cnt_d      = '0;
              cmd_addr_d = '0;
              state_d    = (DUMMY_CYCLES == 0) ? DATA : DUMMY;
            end else begin
              cnt_d      = cnt_q + CNT_W'(1);
              cmd_addr_d = addr_nibble(addr_q, cnt_q + CNT_W'(1));
            end
          end
        end

        DUMMY: begin
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            if (cnt_q == CNT_W'(DUMMY_CYCLES - 1)) begin
              cnt_d   = '0;
              state_d = DATA;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end

        DATA: begin
          if (!sclk_q) begin
            // Back-pressure only holds the low phase, so no nibble is lost.
            sclk_d = !stall_read;
          end else begin
            sclk_d = 1'b0;
            if (cnt_q == CNT_W'(0)) begin
              nib_d = data_in;
              cnt_d = CNT_W'(1);
            end else begin
              cnt_d   = '0;
              data_d  = {nib_q, data_in};
              ready_d = 1'b1;
              addr_d  = addr_q + ADDR_W'(1);
`ifdef QSPI_SEQUENTIAL_STREAM_EN
              state_d = DATA;
`else
              state_d  = DESELECT;
              select_d = 1'b1;
`endif
            end
          end
        end

        DESELECT: begin
          sclk_d     = 1'b0;
          select_d   = 1'b1;
          cmd_addr_d = '0;
          if (cnt_q == CNT_W'(1)) begin
            cnt_d = '0;
            if (restart_q) begin
              restart_d  = 1'b0;
              state_d    = CMD;
              select_d   = 1'b0;
              cmd_addr_d = READ_CMD[7:4];
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        default: begin
          state_d  = IDLE;
          sclk_d   = 1'b0;
          select_d = 1'b1;
        end
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  assign sclk         = sclk_q;
  assign select       = select_q;
  assign cmd_addr_out = cmd_addr_q;
  assign data_out     = data_q;
  assign data_ready   = ready_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_qspi_flash_reader.sv
// tb_qspi_flash_reader: directed bench for qspi_flash_reader with a nibble-level
// flash model whose byte k holds k[7:0].
module tb_qspi_flash_reader;

  localparam int unsigned DUMMY = 4;

  logic        clk;
  logic        reset;
  logic        start;
  logic [23:0] addr_in;
  logic        stall_read;
  logic [3:0]  data_in;
  logic        sclk;
  logic        select;
  logic [3:0]  cmd_addr_out;
  logic [7:0]  data_out;
  logic        data_ready;
  logic        busy;

  int checks = 0;
  int errors = 0;

  qspi_flash_reader #(.DUMMY_CYCLES(DUMMY), .READ_CMD(8'hEB)) dut (
    .clk(clk), .reset(reset), .start(start), .addr_in(addr_in),
    .stall_read(stall_read), .data_in(data_in), .sclk(sclk), .select(select),
    .cmd_addr_out(cmd_addr_out), .data_out(data_out), .data_ready(data_ready),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flash model: counts rising sclk edges since select fell, decodes the command
  // and address, then returns bytes from the decoded address onward.
  int unsigned emu_n = 0;
  logic [7:0]  cmd_seen = 8'h00;
  logic [23:0] emu_addr = 24'h0;

  always @(posedge sclk or posedge select) begin
    if (select) begin
      emu_n <= 0;
    end else begin
      if (emu_n < 2) cmd_seen <= {cmd_seen[3:0], cmd_addr_out};
      else if (emu_n < 8) emu_addr <= {emu_addr[19:0], cmd_addr_out};
      emu_n <= emu_n + 1;
    end
  end

  always_comb begin
    int unsigned j;
    logic [23:0] b;
    j = 0;
    b = 24'h0;
    data_in = 4'h0;
    if (emu_n > 8 + DUMMY) begin
      j = emu_n - 9 - DUMMY;
      b = emu_addr + 24'(j >> 1);
      data_in = j[0] ? b[3:0] : b[7:4];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  // Pulse start for one cycle; returns in the first cycle after it was sampled.
  task automatic do_start(input logic [23:0] a);
    start   = 1'b1;
    addr_in = a;
    step();
    start   = 1'b0;
  endtask

  // Step until data_ready is seen; n is the number of steps taken (max on timeout).
  task automatic wait_ready(input int max, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!data_ready && n < max);
  endtask

  initial begin
    int n;
    reset      = 1'b1;
    start      = 1'b0;
    addr_in    = 24'h0;
    stall_read = 1'b0;
    step();
    step();

    // Reset state
    chk("rst_select", select, 1);
    chk("rst_sclk", sclk, 0);
    chk("rst_cmd", cmd_addr_out, 0);
    chk("rst_data", data_out, 0);
    chk("rst_ready", data_ready, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    step();

    // Basic read at 0x000100
    do_start(24'h000100);
    chk("r1_select", select, 0);
    chk("r1_busy", busy, 1);
    chk("r1_first_nib", cmd_addr_out, 4'hE);
    chk("r1_sclk_low", sclk, 0);
    wait_ready(100, n);
    chk("r1_latency", n + 1, 29);
    chk("r1_data", data_out, 8'h00);
    chk("r1_cmd", cmd_seen, 8'hEB);
    chk("r1_addr", emu_addr, 24'h000100);

`ifdef QSPI_SEQUENTIAL_STREAM_EN
    // Sequential stream: one byte every 4 clk
    for (int k = 1; k <= 3; k++) begin
      wait_ready(100, n);
      chk("st_period", n, 4);
      chk("st_data", data_out, 32'(k));
    end
    chk("st_select_low", select, 0);

    // Stall mid-stream starting in a low phase
    stall_read = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("st_stall_sclk", sclk, 0);
      chk("st_stall_ready", data_ready, 0);
    end
    stall_read = 1'b0;
    wait_ready(100, n);
    chk("st_stall_period", n, 4);
    chk("st_after_stall", data_out, 8'h04);
    wait_ready(100, n);
    chk("st_next_period", n, 4);
    chk("st_next_data", data_out, 8'h05);

    // Address wrap FFFFFF -> 000000
    do_reset();
    do_start(24'hFFFFFF);
    wait_ready(100, n);
    chk("wrap_latency", n + 1, 29);
    chk("wrap_b0", data_out, 8'hFF);
    wait_ready(100, n);
    chk("wrap_period", n, 4);
    chk("wrap_b1", data_out, 8'h00);
`else
    // Single byte then DESELECT for 2 clk, then IDLE
    chk("r1_deselect0", select, 1);
    step();
    chk("r1_ready_pulse", data_ready, 0);
    chk("r1_deselect1", select, 1);
    chk("r1_busy_desel", busy, 1);
    step();
    chk("r1_idle_busy", busy, 0);
    chk("r1_idle_sclk", sclk, 0);

    // stall_read held through CMD/ADDR/DUMMY has no effect
    stall_read = 1'b1;
    do_start(24'h0000A5);
    for (int k = 0; k < 19; k++) step();
    stall_read = 1'b0;
    wait_ready(100, n);
    chk("ign_stall_latency", n + 20, 29);
    chk("ign_stall_data", data_out, 8'hA5);
    step();
    step();
    step();

    // Another address pattern
    do_start(24'h123456);
    wait_ready(100, n);
    chk("r3_latency", n + 1, 29);
    chk("r3_data", data_out, 8'h56);
    chk("r3_addr", emu_addr, 24'h123456);
    step();
    step();
    step();

    // Stall in DATA from the low phase of the first data period
    do_start(24'h00003C);
    for (int k = 0; k < 24; k++) step();
    chk("stall_sclk_pre", sclk, 0);
    stall_read = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("stall_sclk", sclk, 0);
      chk("stall_select", select, 0);
    end
    stall_read = 1'b0;
    wait_ready(100, n);
    chk("stall_latency", n, 4);
    chk("stall_data", data_out, 8'h3C);
`endif

    // Abort: restart at 0x000200 twelve cycles into a read
    do_reset();
    do_start(24'h000100);
    for (int k = 0; k < 11; k++) step();
    start   = 1'b1;
    addr_in = 24'h000200;
    step();
    start = 1'b0;
    chk("ab_select0", select, 1);
    chk("ab_sclk0", sclk, 0);
    chk("ab_busy", busy, 1);
    step();
    chk("ab_select1", select, 1);
    chk("ab_ready", data_ready, 0);
    step();
    chk("ab_select_low", select, 0);
    chk("ab_cmd", cmd_addr_out, 4'hE);
    wait_ready(100, n);
    chk("ab_latency", n, 28);
    chk("ab_data", data_out, 8'h00);
    chk("ab_addr", emu_addr, 24'h000200);
    chk("ab_cmd_seen", cmd_seen, 8'hEB);

    // Reset during DUMMY, then a full new read
    do_reset();
    do_start(24'h000100);
    for (int k = 0; k < 18; k++) step();
    reset = 1'b1;
    step();
    chk("rd_select", select, 1);
    chk("rd_sclk", sclk, 0);
    chk("rd_busy", busy, 0);
    chk("rd_ready", data_ready, 0);
    chk("rd_cmd", cmd_addr_out, 0);
    reset = 1'b0;
    step();
    do_start(24'h0000FE);
    wait_ready(100, n);
    chk("rd_latency", n + 1, 29);
    chk("rd_data", data_out, 8'hFE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
